// File: rtl/tpg_pkg.sv
// Shared types and constants for the Bayer test-pattern generator.
package tpg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FV_LEAD  = 3'd1,
    ST_LINE     = 3'd2,
    ST_HBLANK   = 3'd3,
    ST_FV_TRAIL = 3'd4,
    ST_VBLANK   = 3'd5
  } tpg_state_e;

  typedef enum logic [1:0] {
    PAT_FLAT   = 2'd0,
    PAT_HRAMP  = 2'd1,
    PAT_VRAMP  = 2'd2,
    PAT_MOVING = 2'd3
  } tpg_pattern_e;

  localparam int MIN_BLANK = 1;

endpackage

// File: rtl/tpg_timing.sv
// Frame timing for the test-pattern generator: FSM, row/col/blank counters,
// and the per-frame configuration latch with its clamps.
module tpg_timing
  import tpg_pkg::*;
#(
  parameter int PIXEL_BITS = 10,
  parameter int MAX_COLS   = 1920,
  parameter int MAX_ROWS   = 1080,
  parameter int BLANK_BITS = 16,
  parameter int CW         = $clog2(MAX_COLS),
  parameter int RW         = $clog2(MAX_ROWS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [CW-1:0]         width,
  input  logic [RW-1:0]         height,
  input  logic [BLANK_BITS-1:0] hblank,
  input  logic [BLANK_BITS-1:0] vblank,
  input  logic [1:0]            pattern,
  input  logic [PIXEL_BITS-1:0] ch0_level,
  input  logic [PIXEL_BITS-1:0] ch1_level,
  input  logic [PIXEL_BITS-1:0] ch2_level,
  input  logic [PIXEL_BITS-1:0] ch3_level,
  output logic                  fv,
  output logic                  lv,
  output logic                  busy,
  output logic [RW-1:0]         row,
  output logic [CW-1:0]         col,
  output logic [31:0]           frame_count,
  output tpg_pattern_e          cfg_pattern,
  output logic [PIXEL_BITS-1:0] cfg_level0,
  output logic [PIXEL_BITS-1:0] cfg_level1,
  output logic [PIXEL_BITS-1:0] cfg_level2,
  output logic [PIXEL_BITS-1:0] cfg_level3
);

  tpg_state_e            state_r;
  logic [CW-1:0]         w_r, col_r, w_clamp_s;
  logic [RW-1:0]         h_r, row_r, h_clamp_s;
  logic [BLANK_BITS-1:0] hb_r, vb_r, cnt_r, hb_clamp_s, vb_clamp_s;
  logic [31:0]           fc_r;
  logic                  start_s, vblank_done_s, latch_s;

  // Clamp incoming config and decide whether a new frame may start this cycle.
  always_comb begin
    w_clamp_s     = (width > CW'(MAX_COLS)) ? CW'(MAX_COLS) : width;
    h_clamp_s     = (height > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : height;
    hb_clamp_s    = (hblank == '0) ? BLANK_BITS'(MIN_BLANK) : hblank;
    vb_clamp_s    = (vblank == '0) ? BLANK_BITS'(MIN_BLANK) : vblank;
    start_s       = enable && (width != '0) && (height != '0);
    vblank_done_s = (state_r == ST_VBLANK) && (cnt_r == vb_r - BLANK_BITS'(1));
    latch_s       = start_s && ((state_r == ST_IDLE) || vblank_done_s);
  end

  // Frame configuration, captured only at frame start so software may write at any time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_r         <= '0;
      h_r         <= '0;
      hb_r        <= BLANK_BITS'(MIN_BLANK);
      vb_r        <= BLANK_BITS'(MIN_BLANK);
      cfg_pattern <= PAT_FLAT;
      cfg_level0  <= '0;
      cfg_level1  <= '0;
      cfg_level2  <= '0;
      cfg_level3  <= '0;
    end else if (latch_s) begin
      w_r         <= w_clamp_s;
      h_r         <= h_clamp_s;
      hb_r        <= hb_clamp_s;
      vb_r        <= vb_clamp_s;
      cfg_pattern <= tpg_pattern_e'(pattern);
      cfg_level0  <= ch0_level;
      cfg_level1  <= ch1_level;
      cfg_level2  <= ch2_level;
      cfg_level3  <= ch3_level;
    end
  end

  // Frame sequencing FSM with its position and blanking counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      row_r   <= '0;
      col_r   <= '0;
      fc_r    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (latch_s) state_r <= ST_FV_LEAD;
        end
        ST_FV_LEAD: begin
          if (cnt_r == hb_r - BLANK_BITS'(1)) begin
            state_r <= ST_LINE;
            cnt_r   <= '0;
            row_r   <= '0;
            col_r   <= '0;
          end else begin
            cnt_r <= cnt_r + BLANK_BITS'(1);
          end
        end
        ST_LINE: begin
          if (col_r == w_r - CW'(1)) begin
            col_r   <= '0;
            cnt_r   <= '0;
            state_r <= (row_r == h_r - RW'(1)) ? ST_FV_TRAIL : ST_HBLANK;
          end else begin
            col_r <= col_r + CW'(1);
          end
        end
        ST_HBLANK: begin
          if (cnt_r == hb_r - BLANK_BITS'(1)) begin
            state_r <= ST_LINE;
            cnt_r   <= '0;
            row_r   <= row_r + RW'(1);
          end else begin
            cnt_r <= cnt_r + BLANK_BITS'(1);
          end
        end
        ST_FV_TRAIL: begin
          if (cnt_r == hb_r - BLANK_BITS'(1)) begin
            state_r <= ST_VBLANK;
            cnt_r   <= '0;
            fc_r    <= fc_r + 32'd1;
          end else begin
            cnt_r <= cnt_r + BLANK_BITS'(1);
          end
        end
        ST_VBLANK: begin
          if (vblank_done_s) begin
            cnt_r   <= '0;
            state_r <= latch_s ? ST_FV_LEAD : ST_IDLE;
          end else begin
            cnt_r <= cnt_r + BLANK_BITS'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign fv          = (state_r == ST_FV_LEAD) || (state_r == ST_LINE) ||
                       (state_r == ST_HBLANK)  || (state_r == ST_FV_TRAIL);
  assign lv          = (state_r == ST_LINE);
  assign busy        = (state_r != ST_IDLE);
  assign row         = row_r;
  assign col         = col_r;
  assign frame_count = fc_r;

endmodule

// File: rtl/bayer_tpg.sv
// Bayer GRBG test-pattern generator: frame timing plus a registered pattern
// mux, with fv/lv/data/frame_count/busy all leaving from one register stage.
module bayer_tpg
  import tpg_pkg::*;
#(
  parameter int PIXEL_BITS = 10,
  parameter int MAX_COLS   = 1920,
  parameter int MAX_ROWS   = 1080,
  parameter int BLANK_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [$clog2(MAX_COLS)-1:0]  width,
  input  logic [$clog2(MAX_ROWS)-1:0]  height,
  input  logic [BLANK_BITS-1:0]        hblank,
  input  logic [BLANK_BITS-1:0]        vblank,
  input  logic [1:0]                   pattern,
  input  logic [PIXEL_BITS-1:0]        ch0_level,
  input  logic [PIXEL_BITS-1:0]        ch1_level,
  input  logic [PIXEL_BITS-1:0]        ch2_level,
  input  logic [PIXEL_BITS-1:0]        ch3_level,
  output logic                         o_fv,
  output logic                         o_lv,
  output logic [PIXEL_BITS-1:0]        o_data,
  output logic [31:0]                  frame_count,
  output logic                         busy
);

  localparam int CW = $clog2(MAX_COLS);
  localparam int RW = $clog2(MAX_ROWS);

  logic                  fv_s, lv_s, busy_s;
  logic [RW-1:0]         row_s;
  logic [CW-1:0]         col_s;
  logic [31:0]           fc_s;
  tpg_pattern_e          pat_s;
  logic [PIXEL_BITS-1:0] lvl0_s, lvl1_s, lvl2_s, lvl3_s, flat_s, pix_s;

  tpg_timing #(
    .PIXEL_BITS(PIXEL_BITS),
    .MAX_COLS  (MAX_COLS),
    .MAX_ROWS  (MAX_ROWS),
    .BLANK_BITS(BLANK_BITS)
  ) u_timing (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .width      (width),
    .height     (height),
    .hblank     (hblank),
    .vblank     (vblank),
    .pattern    (pattern),
    .ch0_level  (ch0_level),
    .ch1_level  (ch1_level),
    .ch2_level  (ch2_level),
    .ch3_level  (ch3_level),
    .fv         (fv_s),
    .lv         (lv_s),
    .busy       (busy_s),
    .row        (row_s),
    .col        (col_s),
    .frame_count(fc_s),
    .cfg_pattern(pat_s),
    .cfg_level0 (lvl0_s),
    .cfg_level1 (lvl1_s),
    .cfg_level2 (lvl2_s),
    .cfg_level3 (lvl3_s)
  );

  // Pattern selection; the Bayer channel is {row[0], col[0]}.
  always_comb begin
    case ({row_s[0], col_s[0]})
      2'b00:   flat_s = lvl0_s;
      2'b01:   flat_s = lvl1_s;
      2'b10:   flat_s = lvl2_s;
      2'b11:   flat_s = lvl3_s;
      default: flat_s = '0;
    endcase
    case (pat_s)
      PAT_FLAT:   pix_s = flat_s;
      PAT_HRAMP:  pix_s = PIXEL_BITS'(col_s);
      PAT_VRAMP:  pix_s = PIXEL_BITS'(row_s);
      PAT_MOVING: pix_s = fc_s[PIXEL_BITS-1:0] + PIXEL_BITS'(row_s) + PIXEL_BITS'(col_s);
      default:    pix_s = '0;
    endcase
  end

  // Output stage: timing and data share one register so they stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_fv        <= 1'b0;
      o_lv        <= 1'b0;
      o_data      <= '0;
      frame_count <= 32'd0;
      busy        <= 1'b0;
    end else begin
      o_fv        <= fv_s;
      o_lv        <= lv_s;
      o_data      <= lv_s ? pix_s : '0;
      frame_count <= fc_s;
      busy        <= busy_s;
    end
  end

endmodule

// File: tb/tb_bayer_tpg.sv
// Self-checking bench for bayer_tpg: directed scenarios plus random config
// churn, compared cycle by cycle against a frame-level reference model.
module tb_bayer_tpg;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] width, height;
  logic [15:0] hblank, vblank;
  logic [1:0]  pattern;
  logic [9:0]  ch0_level, ch1_level, ch2_level, ch3_level;
  logic        o_fv, o_lv, busy;
  logic [9:0]  o_data;
  logic [31:0] frame_count;

  typedef struct packed {
    logic        fv;
    logic        lv;
    logic [9:0]  data;
    logic [31:0] fc;
    logic        busy;
  } obs_t;

  obs_t        q[$];
  obs_t        exp_out;
  int unsigned m_fc = 0;
  int          checks = 0;
  int          errors = 0;

  bayer_tpg dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .width(width), .height(height), .hblank(hblank), .vblank(vblank),
    .pattern(pattern),
    .ch0_level(ch0_level), .ch1_level(ch1_level),
    .ch2_level(ch2_level), .ch3_level(ch3_level),
    .o_fv(o_fv), .o_lv(o_lv), .o_data(o_data),
    .frame_count(frame_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(logic fv, logic lv, int unsigned data, int unsigned fc, logic busy_v);
    obs_t e;
    e.fv   = fv;
    e.lv   = lv;
    e.data = 10'(data % 1024);
    e.fc   = fc;
    e.busy = busy_v;
    return e;
  endfunction

  // Whole-frame reference: expected outputs of one frame plus its vblank.
  task automatic build_frame();
    int w, h, hb, vb, pat, v;
    int lvl[4];
    w   = (width > 11'd1920) ? 1920 : int'(width);
    h   = (height > 11'd1080) ? 1080 : int'(height);
    hb  = (hblank == 16'd0) ? 1 : int'(hblank);
    vb  = (vblank == 16'd0) ? 1 : int'(vblank);
    pat = int'(pattern);
    lvl[0] = int'(ch0_level); lvl[1] = int'(ch1_level);
    lvl[2] = int'(ch2_level); lvl[3] = int'(ch3_level);
    for (int i = 0; i < hb; i++) q.push_back(mk(1'b1, 1'b0, 0, m_fc, 1'b1));
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        case (pat)
          0:       v = lvl[(r % 2) * 2 + (c % 2)];
          1:       v = c;
          2:       v = r;
          default: v = int'(m_fc % 1024) + r + c;
        endcase
        q.push_back(mk(1'b1, 1'b1, v, m_fc, 1'b1));
      end
      if (r < h - 1)
        for (int i = 0; i < hb; i++) q.push_back(mk(1'b1, 1'b0, 0, m_fc, 1'b1));
    end
    for (int i = 0; i < hb; i++) q.push_back(mk(1'b1, 1'b0, 0, m_fc, 1'b1));
    for (int i = 0; i < vb; i++) q.push_back(mk(1'b0, 1'b0, 0, m_fc + 1, 1'b1));
    m_fc++;
  endtask

  task automatic model_step(output obs_t nxt);
    if (!reset_n) begin
      q.delete();
      m_fc = 0;
      nxt  = mk(1'b0, 1'b0, 0, 0, 1'b0);
    end else if (q.size() > 0) begin
      nxt = q.pop_front();
    end else if (enable && width != 11'd0 && height != 11'd0) begin
      build_frame();
      nxt = q.pop_front();
    end else begin
      nxt = mk(1'b0, 1'b0, 0, m_fc, 1'b0);
    end
  endtask

  task automatic check(string tag, obs_t e);
    obs_t o;
    o = {o_fv, o_lv, o_data, frame_count, busy};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s t=%0t got fv=%b lv=%b data=%0d fc=%0d busy=%b want fv=%b lv=%b data=%0d fc=%0d busy=%b",
             tag, $time, o.fv, o.lv, o.data, o.fc, o.busy, e.fv, e.lv, e.data, e.fc, e.busy);
    end
  endtask

  task automatic tick();
    obs_t nxt;
    @(posedge clk);
    model_step(nxt);
    @(negedge clk);
    check("stream", exp_out);
    exp_out = nxt;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1 check("async_rst", mk(1'b0, 1'b0, 0, 0, 1'b0));
    q.delete();
    m_fc    = 0;
    exp_out = mk(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic set_cfg(int w, int h, int hb, int vb, int pat);
    width   = 11'(w);
    height  = 11'(h);
    hblank  = 16'(hb);
    vblank  = 16'(vb);
    pattern = 2'(pat);
  endtask

  initial begin
    exp_out = mk(1'b0, 1'b0, 0, 0, 1'b0);
    set_cfg(4, 2, 2, 3, 0);
    ch0_level = 10'd10; ch1_level = 10'd20; ch2_level = 10'd30; ch3_level = 10'd40;
    ticks(3);
    check("reset", mk(1'b0, 1'b0, 0, 0, 1'b0));

    // Basic frames
    reset_n = 1'b1;
    enable  = 1'b1;
    ticks(36);

    // Zero blanking clamps
    set_cfg(3, 1, 0, 0, 0);
    ticks(24);

    // Disable mid-frame
    set_cfg(4, 2, 2, 3, 0);
    ticks(20);
    enable = 1'b0;
    ticks(30);

    // Config change while a line is running
    enable = 1'b1;
    ticks(5);
    width = 11'd6;
    ticks(50);

    // Async reset during a line, then restart
    set_cfg(4, 2, 2, 3, 0);
    ticks(24);
    async_reset();
    ticks(2);
    reset_n = 1'b1;
    ticks(30);

    // Wide ramps: HRAMP frame 0, VRAMP frame 1, MOVING frame 2
    async_reset();
    ticks(2);
    set_cfg(1025, 2, 2, 2, 1);
    reset_n = 1'b1;
    ticks(100);
    pattern = 2'd2;
    ticks(2058);
    pattern = 2'd3;
    ticks(2058);
    ticks(1900);

    // Random config churn
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        set_cfg($urandom_range(0, 8), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
        ch0_level = 10'($urandom_range(0, 1023));
        ch1_level = 10'($urandom_range(0, 1023));
        ch2_level = 10'($urandom_range(0, 1023));
        ch3_level = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      tick();
    end

    // Width clamp to MAX_COLS
    set_cfg(2000, 1, 1, 1, 1);
    enable = 1'b1;
    ticks(4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
